// File: rtl/ahb2apb_req_arbiter_pkg.sv
// Shared types and constants for the ahb2apb request arbiter.
package ahb2apb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Width of a requester index; never below 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb2apb_req_arbiter_if.sv
// Requester-side and AHB-side signals of the arbiter.
// With AHB2APB_ARB_TIMEOUT_EN defined the bundle also carries timeout_flag.
interface ahb2apb_req_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // requester side
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rdata;
  logic                    err;
  // AHB side
  logic                    hsel;
  logic [ADDR_W-1:0]       haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [DATA_W-1:0]       hwdata;
  logic [DATA_W-1:0]       hrdata;
  logic                    hready;
  logic                    hresp;
`ifdef AHB2APB_ARB_TIMEOUT_EN
  logic                    timeout_flag;
`endif

  // Arbiter view: drives grants and the AHB master signals.
  modport master (
    input  req, req_write, req_addr, req_wdata, hrdata, hready, hresp,
    output gnt, done, rdata, err, hsel, haddr, htrans, hwrite, hsize, hwdata
`ifdef AHB2APB_ARB_TIMEOUT_EN
    , output timeout_flag
`endif
  );

  // Environment view: requesters plus the bridge slave port.
  modport slave (
    output req, req_write, req_addr, req_wdata, hrdata, hready, hresp,
    input  gnt, done, rdata, err, hsel, haddr, htrans, hwrite, hsize, hwdata
`ifdef AHB2APB_ARB_TIMEOUT_EN
    , input timeout_flag
`endif
  );

endinterface

// File: rtl/ahb2apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  // Scan from the pointer, wrapping at N_REQ-1, keep the first hit.
  always_comb begin
    int unsigned j;
    j       = 0;
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!o_any_c && i_req[j]) begin
        o_any_c    = 1'b1;
        o_gnt_c[j] = 1'b1;
        o_idx_c    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ahb2apb_req_arbiter.sv
// Round-robin sharing of the bridge AHB-Lite slave port between N_REQ
// requesters; one transfer at a time, IDLE -> ADDR -> DATA -> IDLE.
// Optional wait-state timeout: define AHB2APB_ARB_TIMEOUT_EN.
module ahb2apb_req_arbiter
  import ahb2apb_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef AHB2APB_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahb2apb_req_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_w(N_REQ);
`ifdef AHB2APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gidx;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_hsel;
  logic [ADDR_W-1:0] r_haddr;
  htrans_t           r_htrans;
  logic              r_hwrite;
  logic [DATA_W-1:0] r_hwdata;
`ifdef AHB2APB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_timeout_flag;
`endif

  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_any;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [ADDR_W-1:0] w_addr  [N_REQ];
  logic [DATA_W-1:0] w_wdata [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_gidx),
    .o_any_c (w_any)
  );

  // Unpack per-requester address and write data.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      w_wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_ptr_next = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);

  // Arbitration FSM with registered AHB and requester outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_gidx         <= '0;
      r_gnt          <= '0;
      r_done         <= '0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
      r_hsel         <= 1'b0;
      r_haddr        <= '0;
      r_htrans       <= HTRANS_IDLE;
      r_hwrite       <= 1'b0;
      r_hwdata       <= '0;
`ifdef AHB2APB_ARB_TIMEOUT_EN
      r_wait_cnt     <= '0;
      r_timeout_flag <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_gnt;
            r_gidx   <= w_gidx;
            r_haddr  <= w_addr[w_gidx] & ~ADDR_W'(3);
            r_hwrite <= bus.req_write[w_gidx];
            r_hsel   <= 1'b1;
            r_htrans <= HTRANS_NONSEQ;
            r_state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.hready) begin
            r_htrans   <= HTRANS_IDLE;
            r_hwdata   <= w_wdata[r_gidx];
            r_state    <= ST_DATA;
`ifdef AHB2APB_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        ST_DATA: begin
          if (bus.hready) begin
            r_done <= r_gnt;
            if (!r_hwrite) r_rdata <= bus.hrdata;
            r_err   <= bus.hresp;
            r_gnt   <= '0;
            r_hsel  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
`ifdef AHB2APB_ARB_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // slave stuck: abandon the transfer and report an error
            r_done         <= r_gnt;
            r_err          <= 1'b1;
            r_gnt          <= '0;
            r_hsel         <= 1'b0;
            r_htrans       <= HTRANS_IDLE;
            r_ptr          <= w_ptr_next;
            r_timeout_flag <= 1'b1;
            r_state        <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;
  assign bus.err    = r_err;
  assign bus.hsel   = r_hsel;
  assign bus.haddr  = r_haddr;
  assign bus.htrans = r_htrans;
  assign bus.hwrite = r_hwrite;
  assign bus.hsize  = HSIZE_WORD;
  assign bus.hwdata = r_hwdata;
`ifdef AHB2APB_ARB_TIMEOUT_EN
  assign bus.timeout_flag = r_timeout_flag;
`endif

endmodule

// File: tb/tb_ahb2apb_req_arbiter.sv
// Directed bench for ahb2apb_req_arbiter; the bench plays requesters and slave.
// Timeout steps run only when AHB2APB_ARB_TIMEOUT_EN is defined.
module tb_ahb2apb_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          hclk = 1'b0;
  logic          hreset;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_rdata;

  ahb2apb_req_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb2apb_req_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
`ifdef AHB2APB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (8)
`endif
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer from requester r; the bench is at a negedge with the FSM idle.
  task automatic xfer(input int r, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rd,
                      input int waits, input logic resp_err);
    logic [N-1:0] oh;
    oh = N'(1) << r;
    bus.req[r]                 = 1'b1;
    bus.req_write[r]           = wr;
    bus.req_addr[r*AW +: AW]   = addr;
    bus.req_wdata[r*DW +: DW]  = wdata;
    bus.hready                 = 1'b1;
    bus.hresp                  = 1'b0;
    @(negedge hclk);
    chk("addr_htrans", 64'(bus.htrans), 64'(2'b10));
    chk("addr_gnt", 64'(bus.gnt), 64'(oh));
    chk("addr_haddr", 64'(bus.haddr), 64'(addr & ~32'h3));
    chk("addr_hwrite", 64'(bus.hwrite), 64'(wr));
    chk("addr_hsel", 64'(bus.hsel), 64'(1'b1));
    @(negedge hclk);
    chk("data_htrans", 64'(bus.htrans), 64'(2'b00));
    if (wr) chk("data_hwdata", 64'(bus.hwdata), 64'(wdata));
    for (int w = 0; w < waits; w++) begin
      bus.hready = 1'b0;
      bus.hresp  = resp_err && (w == waits - 1);
      @(negedge hclk);
      chk("wait_done", 64'(bus.done), 64'(0));
      chk("wait_gnt", 64'(bus.gnt), 64'(oh));
    end
    bus.hready = 1'b1;
    bus.hresp  = resp_err;
    bus.hrdata = rd;
    @(negedge hclk);
    if (!wr) exp_rdata = rd;
    chk("cmpl_done", 64'(bus.done), 64'(oh));
    chk("cmpl_err", 64'(bus.err), 64'(resp_err));
    chk("cmpl_rdata", 64'(bus.rdata), 64'(exp_rdata));
    chk("cmpl_gnt", 64'(bus.gnt), 64'(0));
    chk("cmpl_hsel", 64'(bus.hsel), 64'(0));
    bus.req[r] = 1'b0;
    bus.hresp  = 1'b0;
  endtask

  initial begin
    logic [N-1:0] oh;
    hreset        = 1'b1;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    exp_rdata     = '0;

    // reset state
    repeat (2) @(negedge hclk);
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_rdata", 64'(bus.rdata), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_hsel", 64'(bus.hsel), 64'(0));
    chk("rst_haddr", 64'(bus.haddr), 64'(0));
    chk("rst_htrans", 64'(bus.htrans), 64'(0));
    chk("rst_hwrite", 64'(bus.hwrite), 64'(0));
    chk("rst_hwdata", 64'(bus.hwdata), 64'(0));
    chk("rst_hsize", 64'(bus.hsize), 64'(3'b010));
    hreset = 1'b0;
    @(negedge hclk);

    // single write, zero-wait slave (ptr 0 -> 1)
    xfer(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 0, 1'b0);
    @(negedge hclk);
    chk("t1_done_once", 64'(bus.done), 64'(0));
    chk("t1_idle_htrans", 64'(bus.htrans), 64'(0));

    // single read with two wait states (ptr 1 -> 3)
    xfer(2, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 2, 1'b0);
    @(negedge hclk);

    // two-cycle ERROR response on a write (ptr 3 -> 2)
    xfer(1, 1'b1, 32'h0000_0030, 32'h5555_AAAA, 32'h0, 1, 1'b1);
    @(negedge hclk);

    // next transfer OKAY, unaligned address low bits dropped (ptr 2 -> 3)
    xfer(2, 1'b0, 32'h0000_0047, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    @(negedge hclk);

    // reset while in DATA; transfer from requester 1 is dropped
    bus.req[1]          = 1'b1;
    bus.req_write[1]    = 1'b0;
    bus.req_addr[AW +: AW] = 32'h0000_0050;
    @(negedge hclk);
    chk("rstm_gnt", 64'(bus.gnt), 64'(4'b0010));
    @(negedge hclk);
    bus.hready = 1'b0;
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    chk("rstm_htrans", 64'(bus.htrans), 64'(0));
    chk("rstm_gnt0", 64'(bus.gnt), 64'(0));
    chk("rstm_hsel", 64'(bus.hsel), 64'(0));
    chk("rstm_rdata", 64'(bus.rdata), 64'(0));
    exp_rdata = '0;
    bus.req   = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_addr[i*AW +: AW]  = 32'h0000_0100 + 32'(i * 4);
      bus.req_wdata[i*DW +: DW] = 32'hB000_0000 + 32'(i);
    end
    bus.req_write = '1;
    @(negedge hclk);
    hreset     = 1'b0;
    bus.hready = 1'b1;
    bus.req    = '1;

    // all requesters held: grant order 0,1,2,3,0,1,2,3 starting from a reset pointer
    for (int t = 0; t < 8; t++) begin
      oh = N'(1) << (t % 4);
      @(negedge hclk);
      chk("rr_gnt", 64'(bus.gnt), 64'(oh));
      chk("rr_haddr", 64'(bus.haddr), 64'(32'h0000_0100 + 32'((t % 4) * 4)));
      chk("rr_htrans", 64'(bus.htrans), 64'(2'b10));
      @(negedge hclk);
      chk("rr_onehot", 64'($onehot0(bus.gnt)), 64'(1));
      chk("rr_hwdata", 64'(bus.hwdata), 64'(32'hB000_0000 + 32'(t % 4)));
      @(negedge hclk);
      chk("rr_done", 64'(bus.done), 64'(oh));
      chk("rr_err", 64'(bus.err), 64'(0));
      chk("rr_rdata", 64'(bus.rdata), 64'(exp_rdata));
    end
    bus.req = '0;
    @(negedge hclk);
    chk("rr_end_gnt", 64'(bus.gnt), 64'(0));
    chk("rr_end_done", 64'(bus.done), 64'(0));

`ifdef AHB2APB_ARB_TIMEOUT_EN
    // slave never returns hready: timeout after 8 DATA cycles (ptr 0)
    @(negedge hclk);
    bus.req[0]       = 1'b1;
    bus.req_write[0] = 1'b0;
    bus.req_addr[0 +: AW] = 32'h0000_0060;
    @(negedge hclk);
    chk("to_gnt", 64'(bus.gnt), 64'(4'b0001));
    chk("to_flag0", 64'(bus.timeout_flag), 64'(0));
    @(negedge hclk);
    bus.hready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge hclk);
      chk("to_wait_done", 64'(bus.done), 64'(0));
    end
    @(negedge hclk);
    chk("to_done", 64'(bus.done), 64'(4'b0001));
    chk("to_err", 64'(bus.err), 64'(1));
    chk("to_hsel", 64'(bus.hsel), 64'(0));
    chk("to_htrans", 64'(bus.htrans), 64'(0));
    chk("to_gnt0", 64'(bus.gnt), 64'(0));
    chk("to_flag", 64'(bus.timeout_flag), 64'(1));
    bus.req    = '0;
    bus.hready = 1'b1;
    repeat (3) @(negedge hclk);
    chk("to_flag_sticky", 64'(bus.timeout_flag), 64'(1));
    chk("to_done_low", 64'(bus.done), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
